// File: rtl/mbus_memory_pkg.sv
// ---------------------------------------------------------------------------
// mbus_memory_pkg
//   Types and helpers shared by the MBOX memory slave and its storage array.
//   - tMemState   : transfer state machine encoding
//   - W36         : one 36-bit memory word, bit 0 is the MSB
//   - oddParity36 : parity bit that makes the count of ones in {word, bit} odd
// ---------------------------------------------------------------------------
package mbus_memory_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RD   = 2'd2,
      WR   = 2'd3
   } tMemState;

   typedef logic [0:35] W36;

   function automatic logic oddParity36(input W36 w);
      return ~^w;
   endfunction

endpackage

// File: rtl/mbus_mem_array.sv
// ---------------------------------------------------------------------------
// mbus_mem_array
//   Single-port word array with synchronous write and registered read.
//   The read register only updates on a read, so rdata_o holds the last word
//   read for as long as no new read is issued.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (read register only)
//   we_i        write wdata_i to addr_i at the clock edge
//   re_i        load the word at addr_i into the read register
//   addr_i      word address, DEPTH_LOG2 bits
//   wdata_i     write word
//   rdata_o     registered read word
// ---------------------------------------------------------------------------
module mbus_mem_array
   import mbus_memory_pkg::*;
#(
   parameter int DEPTH_LOG2 = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we_i,
   input  logic                  re_i,
   input  logic [DEPTH_LOG2-1:0] addr_i,
   input  logic [0:35]           wdata_i,
   output logic [0:35]           rdata_o
);

   W36 mem_q [0:(2**DEPTH_LOG2)-1];
   W36 rdata_q;

   // NOTE: the storage itself has no reset branch; resetting a RAM array
   // would force it into flops and its contents are undefined after reset.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/mbus_memory.sv
// ---------------------------------------------------------------------------
// mbus_memory
//   Memory slave on the two-port MBOX bus. A request on port A or B is
//   acknowledged one cycle after it is sampled; the masked words of the
//   addressed quad-word are then streamed out (reads) or accepted (writes)
//   in wrap-around order starting at adr[34:35].
// Parameters:
//   DEPTH_LOG2  log2 of the array word count (at least 3)
//   ACCESS_LAT  cycles from ack to the first read word (at least 1)
// Configuration:
//   MBUS_MEM_PARITY_EN  when defined, address and write-data parity are
//                       checked and parIn is generated; otherwise parIn and
//                       adrParErr are tied low and adrPar/parOut are ignored.
// Ports:
//   clk, resetN              clock, asynchronous active-low reset
//   memReset                 synchronous abort back to IDLE
//   adr, adrPar              word address and its odd parity
//   startA, startB           request strobes, A has priority
//   rdRq, wrRq               direction; exactly one must be high at start
//   rq                       quad-word word-select mask, bit i = word i
//   dOut, parOut             write word and its odd parity
//   outValidA, outValidB     write word present on dOut
//   acknA, acknB             one-cycle request accept pulse
//   inValidA, inValidB       read word present on dIn
//   dIn, parIn               read word and its odd parity
//   adrParErr                address-parity error pulse
//   error                    sticky error flag
// ---------------------------------------------------------------------------
module mbus_memory
   import mbus_memory_pkg::*;
#(
   parameter int DEPTH_LOG2 = 12,
   parameter int ACCESS_LAT = 2
) (
   input  logic         clk,
   input  logic         resetN,
   input  logic         memReset,
   input  logic [14:35] adr,
   input  logic         adrPar,
   input  logic         startA,
   input  logic         startB,
   input  logic         rdRq,
   input  logic         wrRq,
   input  logic [0:3]   rq,
   input  logic [0:35]  dOut,
   input  logic         parOut,
   input  logic         outValidA,
   input  logic         outValidB,
   output logic         acknA,
   output logic         acknB,
   output logic         inValidA,
   output logic         inValidB,
   output logic [0:35]  dIn,
   output logic         parIn,
   output logic         adrParErr,
   output logic         error
);

   localparam int RW = DEPTH_LOG2 - 2;
   localparam int CW = (ACCESS_LAT > 2) ? $clog2(ACCESS_LAT - 1) : 1;

   tMemState              state_q, state_d;
   logic                  port_b_q, port_b_d;
   logic [0:3]            rem_q, rem_d;
   logic [1:0]            ptr_q, ptr_d;
   logic [RW-1:0]         row_q, row_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  ack_a_q, ack_a_d;
   logic                  ack_b_q, ack_b_d;
   logic                  inv_a_q, inv_a_d;
   logic                  inv_b_q, inv_b_d;
   logic                  ape_q, ape_d;
   logic                  error_q, error_d;

   logic [1:0]            cur;
   logic [0:3]            rem_left;
   logic                  last;
   logic                  mem_we, mem_re;
   logic [DEPTH_LOG2-1:0] mem_addr;
   W36                    rdata;
   logic                  adr_bad, wpar_bad, dir_bad, out_valid;

`ifdef MBUS_MEM_PARITY_EN
   // parIn stays low until the read register holds a real word, so that
   // the all-zero reset value of dIn is not paired with a parity of 1.
   logic par_live_q;

   assign adr_bad  = ~^{adr, adrPar};
   assign wpar_bad = ~^{dOut, parOut};
   assign parIn    = par_live_q & oddParity36(rdata);

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         par_live_q <= 1'b0;
      end else if (mem_re) begin
         par_live_q <= 1'b1;
      end
   end
`else
   logic unused_inputs;

   assign adr_bad       = 1'b0;
   assign wpar_bad      = 1'b0;
   assign parIn         = 1'b0;
   assign unused_inputs = ^{adr[14:35-DEPTH_LOG2], adrPar, parOut};
`endif

   assign dir_bad   = (rdRq == wrRq);
   assign out_valid = port_b_q ? outValidB : outValidA;
   assign mem_addr  = {row_q, cur};

   // Next word to transfer: first still-pending word at or after ptr_q,
   // wrapping 3 -> 0. Pending bits are cleared as words are visited, so
   // each word is transferred at most once.
   always_comb begin
      cur = ptr_q;
      for (int k = 3; k >= 0; k--) begin
         if (rem_q[ptr_q + 2'(k)]) begin
            cur = ptr_q + 2'(k);
         end
      end
      rem_left      = rem_q;
      rem_left[cur] = 1'b0;
      last          = (rem_left == 4'b0000);
   end

   // NOTE: every signal driven here gets its default first, so no path
   // through the case can leave one unassigned and infer a latch.
   always_comb begin
      state_d  = state_q;
      port_b_d = port_b_q;
      rem_d    = rem_q;
      ptr_d    = ptr_q;
      row_d    = row_q;
      cnt_d    = cnt_q;
      error_d  = error_q;
      ack_a_d  = 1'b0;
      ack_b_d  = 1'b0;
      inv_a_d  = 1'b0;
      inv_b_d  = 1'b0;
      ape_d    = 1'b0;
      mem_we   = 1'b0;
      mem_re   = 1'b0;

      if (memReset) begin
         // Abort: drop the rest of the transfer, keep the array untouched.
         state_d = IDLE;
         rem_d   = 4'b0000;
         error_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (startA || startB) begin
                  if (dir_bad || adr_bad) begin
                     error_d = 1'b1;
                     ape_d   = adr_bad;
                  end else begin
                     ack_a_d  = startA;
                     ack_b_d  = ~startA;
                     port_b_d = ~startA;
                     row_d    = adr[36-DEPTH_LOG2:33];
                     ptr_d    = adr[34:35];
                     rem_d    = rq;
                     if (rq == 4'b0000) begin
                        state_d = IDLE;
                     end else if (wrRq) begin
                        state_d = WR;
                     end else if (ACCESS_LAT > 1) begin
                        // The ack cycle is the first WAIT cycle.
                        state_d = WAIT;
                        cnt_d   = CW'(ACCESS_LAT - 2);
                     end else begin
                        state_d = RD;
                     end
                  end
               end
            end

            WAIT: begin
               if (cnt_q == '0) begin
                  state_d = RD;
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end

            // RD issues one array read per cycle; the word and its inValid
            // appear together one cycle later from the read register.
            RD: begin
               mem_re  = 1'b1;
               inv_a_d = ~port_b_q;
               inv_b_d = port_b_q;
               rem_d   = rem_left;
               ptr_d   = cur + 2'd1;
               if (last) begin
                  state_d = IDLE;
               end
            end

            WR: begin
               if (out_valid) begin
                  // A word with bad parity is consumed but not stored.
                  mem_we = ~wpar_bad;
                  if (wpar_bad) begin
                     error_d = 1'b1;
                  end
                  rem_d = rem_left;
                  ptr_d = cur + 2'd1;
                  if (last) begin
                     state_d = IDLE;
                  end
               end
            end

            default: state_d = IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q  <= IDLE;
         port_b_q <= 1'b0;
         rem_q    <= 4'b0000;
         ptr_q    <= 2'd0;
         row_q    <= '0;
         cnt_q    <= '0;
         ack_a_q  <= 1'b0;
         ack_b_q  <= 1'b0;
         inv_a_q  <= 1'b0;
         inv_b_q  <= 1'b0;
         ape_q    <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         port_b_q <= port_b_d;
         rem_q    <= rem_d;
         ptr_q    <= ptr_d;
         row_q    <= row_d;
         cnt_q    <= cnt_d;
         ack_a_q  <= ack_a_d;
         ack_b_q  <= ack_b_d;
         inv_a_q  <= inv_a_d;
         inv_b_q  <= inv_b_d;
         ape_q    <= ape_d;
         error_q  <= error_d;
      end
   end

   mbus_mem_array #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_array (
      .clk     (clk),
      .rst_n   (resetN),
      .we_i    (mem_we),
      .re_i    (mem_re),
      .addr_i  (mem_addr),
      .wdata_i (dOut),
      .rdata_o (rdata)
   );

   assign acknA     = ack_a_q;
   assign acknB     = ack_b_q;
   assign inValidA  = inv_a_q;
   assign inValidB  = inv_b_q;
   assign dIn       = rdata;
   assign adrParErr = ape_q;
   assign error     = error_q;

endmodule

// File: tb/tb_mbus_memory.sv
// ---------------------------------------------------------------------------
// tb_mbus_memory
//   Directed bench for mbus_memory (default parameters). Read words expected
//   from the bench's own memory model are queued when a read is issued and
//   compared as inValid pulses arrive. Builds with or without
//   MBUS_MEM_PARITY_EN.
// ---------------------------------------------------------------------------
module tb_mbus_memory;

`ifdef MBUS_MEM_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   typedef struct {
      logic        port_b;
      logic [0:35] data;
   } rd_exp_t;

   logic         clk = 1'b0;
   logic         resetN, memReset;
   logic [14:35] adr;
   logic         adrPar, startA, startB, rdRq, wrRq;
   logic [0:3]   rq;
   logic [0:35]  dOut;
   logic         parOut, outValidA, outValidB;
   logic         acknA, acknB, inValidA, inValidB;
   logic [0:35]  dIn;
   logic         parIn, adrParErr, error;

   rd_exp_t      sb_q[$];
   logic [0:35]  mdl [16];
   logic [0:35]  wd [4];
   logic [0:35]  last_word;
   int           checks, errors, cyc, pulses, first_iv, req_cyc, ackb_cyc;

   mbus_memory dut (
      .clk       (clk),
      .resetN    (resetN),
      .memReset  (memReset),
      .adr       (adr),
      .adrPar    (adrPar),
      .startA    (startA),
      .startB    (startB),
      .rdRq      (rdRq),
      .wrRq      (wrRq),
      .rq        (rq),
      .dOut      (dOut),
      .parOut    (parOut),
      .outValidA (outValidA),
      .outValidB (outValidB),
      .acknA     (acknA),
      .acknB     (acknB),
      .inValidA  (inValidA),
      .inValidB  (inValidB),
      .dIn       (dIn),
      .parIn     (parIn),
      .adrParErr (adrParErr),
      .error     (error)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle and sample 1 time unit after the edge; any read word
   // on dIn is compared against the head of the scoreboard.
   task automatic step();
      rd_exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      if (inValidA || inValidB) begin
         pulses++;
         if (first_iv < 0) first_iv = cyc;
         if (sb_q.size() == 0) begin
            check("rd_unexpected_word", {inValidA, inValidB}, 2'b00);
         end else begin
            e = sb_q.pop_front();
            check("rd_port", {inValidA, inValidB}, e.port_b ? 2'b01 : 2'b10);
            check("rd_data", dIn, e.data);
            check("rd_parity", parIn, PAR_EN ? ~^e.data : 1'b0);
            last_word = e.data;
         end
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_acknA"}, acknA, 0);
      check({tag, "_acknB"}, acknB, 0);
      check({tag, "_inValidA"}, inValidA, 0);
      check({tag, "_inValidB"}, inValidB, 0);
      check({tag, "_dIn"}, dIn, 0);
      check({tag, "_parIn"}, parIn, 0);
      check({tag, "_adrParErr"}, adrParErr, 0);
      check({tag, "_error"}, error, 0);
   endtask

   // Write the masked words of a[...] from wd[] in transfer order; a stray
   // word is offered on the other port first and must be ignored.
   task automatic wr_req(input logic port_b, input logic [21:0] a, input logic [0:3] mask,
                         input int bad_idx);
      int         idx;
      logic [1:0] w;
      startA = ~port_b; startB = port_b; rdRq = 1'b0; wrRq = 1'b1;
      adr = a; adrPar = ~^a; rq = mask;
      step();
      check("wr_ack_port", {acknA, acknB}, port_b ? 2'b01 : 2'b10);
      startA = 1'b0; startB = 1'b0; wrRq = 1'b0;
      dOut = 36'o707070707070; parOut = ~^dOut;
      outValidA = port_b; outValidB = ~port_b;
      step();
      outValidA = 1'b0; outValidB = 1'b0;
      idx = 0;
      for (int k = 0; k < 4; k++) begin
         w = a[1:0] + 2'(k);
         if (mask[w]) begin
            dOut = wd[idx];
            parOut = (idx == bad_idx) ? ^wd[idx] : ~^wd[idx];
            if (port_b) outValidB = 1'b1;
            else outValidA = 1'b1;
            step();
            if (idx != bad_idx || !PAR_EN) mdl[{a[3:2], w}] = wd[idx];
            idx++;
         end
      end
      outValidA = 1'b0; outValidB = 1'b0;
   endtask

   task automatic rd_req(input logic port_b, input logic [21:0] a, input logic [0:3] mask);
      logic [1:0] w;
      int         n_exp;
      rd_exp_t    e;
      n_exp = 0;
      for (int k = 0; k < 4; k++) begin
         w = a[1:0] + 2'(k);
         if (mask[w]) begin
            e.port_b = port_b;
            e.data   = mdl[{a[3:2], w}];
            sb_q.push_back(e);
            n_exp++;
         end
      end
      startA = ~port_b; startB = port_b; rdRq = 1'b1; wrRq = 1'b0;
      adr = a; adrPar = ~^a; rq = mask;
      pulses = 0; first_iv = -1; req_cyc = cyc;
      step();
      check("rd_ack_port", {acknA, acknB}, port_b ? 2'b01 : 2'b10);
      startA = 1'b0; startB = 1'b0; rdRq = 1'b0;
      for (int n = 0; n < 16 && sb_q.size() > 0; n++) step();
      check("rd_drained", sb_q.size(), 0);
      sb_q.delete();
      step();
      step();
      check("rd_pulse_count", pulses, n_exp);
      if (n_exp > 0) begin
         check("rd_first_latency", first_iv - req_cyc, 3);
         check("rd_dIn_hold", dIn, last_word);
      end
   endtask

   initial begin
      checks = 0; errors = 0; cyc = 0; pulses = 0; first_iv = -1;
      req_cyc = 0; ackb_cyc = -1; last_word = '0;
      resetN = 1'b0; memReset = 1'b0; adr = '0; adrPar = 1'b0;
      startA = 1'b0; startB = 1'b0; rdRq = 1'b0; wrRq = 1'b0; rq = 4'b0000;
      dOut = '0; parOut = 1'b0; outValidA = 1'b0; outValidB = 1'b0;

      // Reset state.
      step();
      step();
      check_zero("reset");
      resetN = 1'b1;
      step();

      // Fill words 0..3, then read back starting at word 2.
      wd = '{36'o1, 36'o2, 36'o3, 36'o4};
      wr_req(1'b0, 22'd0, 4'b1111, -1);
      rd_req(1'b0, 22'd2, 4'b1111);

      // Sparse mask from word 3: words 3 then 1.
      rd_req(1'b0, 22'd3, 4'b0101);

      // Empty mask: ack only, no data phase.
      rd_req(1'b1, 22'd0, 4'b0000);

      // Simultaneous starts: A first, B held until accepted.
      sb_q.push_back('{port_b: 1'b0, data: mdl[0]});
      sb_q.push_back('{port_b: 1'b1, data: mdl[1]});
      startA = 1'b1; startB = 1'b1; rdRq = 1'b1; wrRq = 1'b0;
      adr = 22'd0; adrPar = ~^22'd0; rq = 4'b1000;
      pulses = 0; first_iv = -1; req_cyc = cyc; ackb_cyc = -1;
      step();
      check("arb_ackA_first", {acknA, acknB}, 2'b10);
      startA = 1'b0; adr = 22'd1; adrPar = ~^22'd1; rq = 4'b0100;
      for (int n = 0; n < 20 && (ackb_cyc < 0 || sb_q.size() > 0); n++) begin
         step();
         if (acknB && ackb_cyc < 0) begin
            ackb_cyc = cyc;
            check("arb_no_ackA_overlap", acknA, 0);
            startB = 1'b0; rdRq = 1'b0;
         end
      end
      check("arb_ackB_seen", ackb_cyc >= 0, 1);
      check("arb_B_after_A_data", ackb_cyc > first_iv, 1);
      check("arb_drained", sb_q.size(), 0);
      sb_q.delete();
      check("arb_pulse_count", pulses, 2);
      step();

      // Abort after the second of four read words.
      sb_q.push_back('{port_b: 1'b0, data: mdl[0]});
      sb_q.push_back('{port_b: 1'b0, data: mdl[1]});
      startA = 1'b1; rdRq = 1'b1; wrRq = 1'b0;
      adr = 22'd0; adrPar = ~^22'd0; rq = 4'b1111;
      pulses = 0; first_iv = -1;
      step();
      check("abort_ack", acknA, 1);
      startA = 1'b0; rdRq = 1'b0;
      for (int n = 0; n < 16 && pulses < 2; n++) step();
      check("abort_two_words", pulses, 2);
      memReset = 1'b1;
      step();
      memReset = 1'b0;
      check("abort_inValid_cleared", {inValidA, inValidB}, 2'b00);
      step();
      step();
      step();
      check("abort_no_more_words", pulses, 2);
      rd_req(1'b0, 22'd0, 4'b1111);

      // Illegal direction: both high, then both low.
      startA = 1'b1; rdRq = 1'b1; wrRq = 1'b1; adr = 22'd0; adrPar = ~^22'd0; rq = 4'b1111;
      step();
      startA = 1'b0; rdRq = 1'b0; wrRq = 1'b0;
      check("dir_both_no_ack", {acknA, acknB}, 2'b00);
      check("dir_both_error", error, 1);
      step();
      check("dir_error_sticky", error, 1);
      memReset = 1'b1;
      step();
      memReset = 1'b0;
      check("memreset_clears_error", error, 0);
      startB = 1'b1;
      step();
      startB = 1'b0;
      check("dir_none_no_ack", {acknA, acknB}, 2'b00);
      check("dir_none_error", error, 1);
      memReset = 1'b1;
      step();
      memReset = 1'b0;

      // Bad address parity (checked only with parity enabled).
      startA = 1'b1; rdRq = 1'b1; wrRq = 1'b0; adr = 22'd5; adrPar = ^22'd5; rq = 4'b0000;
      step();
      startA = 1'b0; rdRq = 1'b0;
      check("apar_err_pulse", adrParErr, PAR_EN);
      check("apar_ack", acknA, !PAR_EN);
      check("apar_error", error, PAR_EN);
      step();
      check("apar_pulse_one_cycle", adrParErr, 0);
      memReset = 1'b1;
      step();
      memReset = 1'b0;

      // Bad write parity on transfer word 1 of 4.
      wd = '{36'o11, 36'o12, 36'o13, 36'o14};
      wr_req(1'b0, 22'd0, 4'b1111, 1);
      check("wpar_error", error, PAR_EN);
      rd_req(1'b0, 22'd0, 4'b1111);

      // Asynchronous reset in the middle of a port B write.
      startB = 1'b1; rdRq = 1'b0; wrRq = 1'b1; adr = 22'd8; adrPar = ~^22'd8; rq = 4'b1111;
      step();
      check("rst_pre_ackB", acknB, 1);
      startB = 1'b0; wrRq = 1'b0;
      #1 resetN = 1'b0;
      #1;
      check_zero("async_rst");
      #2 resetN = 1'b1;
      step();
      rd_req(1'b1, 22'd0, 4'b0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
